muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit_pkg.sv | 33 +++
 rtl/muldiv_div_iter.sv | 56 +++++
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, FSM state encoding and divide context for the HI/LO multiply/divide unit.
// Pure declarations; no timing or flow-control behaviour.
package muldiv_unit_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL     = 2'd1,
    S_DIV     = 2'd2,
    S_DIV_FIX = 2'd3
  } state_t;

  typedef struct packed {
    logic q_neg;
    logic r_neg;
    logic by_zero;
  } div_ctx_t;

  function automatic logic is_div(input logic [2:0] o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic is_mul(input logic [2:0] o);
    return (o == OP_MULT) || (o == OP_MULTU);
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Radix-2 restoring divide core on unsigned magnitudes: one quotient bit per step.
// start loads operands; WIDTH steps produce quot/rem; last flags the final step; no backpressure.
module muldiv_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             qbit;

  // Dividend bits shift out of the quotient register into the partial remainder.
  always_comb begin
    shifted = {rem_q, quot_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr_q};
    qbit    = ~diff[WIDTH];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      rem_q  <= '0;
      quot_q <= dividend;
      dvsr_q <= divisor;
      cnt_q  <= '0;
    end else if (step) begin
      rem_q  <= qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quot_q <= {quot_q[WIDTH-2:0], qbit};
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign last = (cnt_q == CW'(WIDTH - 1));
  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO owner: pipelined MULT/MULTU, iterative DIV/DIVU, immediate MTHI/MTLO; cancel flushes work.
// MUL done after MUL_STAGES cycles, DIV after WIDTH+1 (div-by-zero after 1); req_ready low while busy.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MCW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

  state_t           state;
  div_ctx_t         ctx;
  logic [WIDTH-1:0] a_hold;
  logic [MCW-1:0]   mul_cnt;
  logic             accept;

  logic               sext_a;
  logic               sext_b;
  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] mul_b;
  logic [2*WIDTH-1:0] mul_prod;
  logic [2*WIDTH-1:0] mul_pipe [MUL_STAGES];

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;
  logic             div_last;
  logic             div_start;
  logic             div_step;
  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid && req_ready && !cancel;

  // Sign-extending to 2*WIDTH makes the truncated product exact for both signed and unsigned.
  always_comb begin
    sext_a   = (op == OP_MULT) && a[WIDTH-1];
    sext_b   = (op == OP_MULT) && b[WIDTH-1];
    mul_a    = {{WIDTH{sext_a}}, a};
    mul_b    = {{WIDTH{sext_b}}, b};
    mul_prod = mul_a * mul_b;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MUL_STAGES; i++) mul_pipe[i] <= '0;
    end else begin
      if (accept && is_mul(op)) mul_pipe[0] <= mul_prod;
      for (int i = 1; i < MUL_STAGES; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
  end

  always_comb begin
    a_mag = ((op == OP_DIV) && a[WIDTH-1]) ? -a : a;
    b_mag = ((op == OP_DIV) && b[WIDTH-1]) ? -b : b;
  end

  assign div_start = accept && is_div(op);
  assign div_step  = (state == S_DIV);

  muldiv_div_iter #(
    .WIDTH(WIDTH)
  ) u_div_iter (
    .clk      (clk),
    .resetn   (resetn),
    .start    (div_start),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quot     (div_q),
    .rem      (div_r),
    .last     (div_last)
  );

  // MIN / -1 needs no special case: |MIN| / 1 negated wraps back to MIN with remainder 0.
  always_comb begin
    fix_q = ctx.q_neg ? -div_q : div_q;
    fix_r = ctx.r_neg ? -div_r : div_r;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      ctx     <= '0;
      a_hold  <= '0;
      mul_cnt <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                mul_cnt <= '0;
                state   <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                ctx.q_neg   <= (op == OP_DIV) && (a[WIDTH-1] ^ b[WIDTH-1]);
                ctx.r_neg   <= (op == OP_DIV) && a[WIDTH-1];
                ctx.by_zero <= (b == '0);
                a_hold      <= a;
                state       <= (b == '0) ? S_DIV_FIX : S_DIV;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cancel) begin
            state <= S_IDLE;
          end else if (mul_cnt == MCW'(MUL_STAGES - 1)) begin
            {hi, lo} <= mul_pipe[MUL_STAGES-1];
            done     <= 1'b1;
            state    <= S_IDLE;
          end else begin
            mul_cnt <= mul_cnt + 1'b1;
          end
        end
        S_DIV: begin
          if (cancel)        state <= S_IDLE;
          else if (div_last) state <= S_DIV_FIX;
        end
        S_DIV_FIX: begin
          state <= S_IDLE;
          if (!cancel) begin
            done <= 1'b1;
            if (ctx.by_zero) begin
              lo <= '1;
              hi <= a_hold;
            end else begin
              lo <= fix_q;
              hi <= fix_r;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32, MUL_STAGES=2); cycle k is sampled 1ns after edge k.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_unit #(
    .WIDTH(32),
    .MUL_STAGES(2)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drives one request for a single edge; returns sampled in cycle 0.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    req_valid = 1'b1;
    op        = o;
    a         = x;
    b         = y;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    int bad;
    int seen_done;

    resetn    = 1'b0;
    req_valid = 1'b0;
    op        = 3'd0;
    a         = '0;
    b         = '0;
    cancel    = 1'b0;
    tick();
    tick();
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ready", req_ready, 1);
    resetn = 1'b1;
    tick();

    // MULT signed then unsigned, same operands
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult_c0_busy", busy, 1);
    tick();
    check("mult_c1_done", done, 0);
    tick();
    check("mult_c2_done", done, 1);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    check("mult_c2_ready", req_ready, 1);
    tick();
    check("mult_c3_done", done, 0);
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    tick();
    tick();
    check("multu_done", done, 1);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);

    // DIV -7/2 with ready/done timing, then DIVU
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    bad = 0;
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (req_ready !== 1'b0 || done !== 1'b0) bad++;
    end
    check("div_busy_cycles_1_32", bad, 0);
    tick();
    check("div_c33_done", done, 1);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2);
    repeat (33) tick();
    check("divu_done", done, 1);
    check("divu_lo", lo, 32'h7FFF_FFFC);
    check("divu_hi", hi, 32'h0000_0001);

    // Signed overflow and divide by zero
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (33) tick();
    check("ovf_done", done, 1);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0);
    issue(OP_DIVU, 32'd5, 32'd0);
    check("dz_c0_ready", req_ready, 0);
    tick();
    check("dz_c1_done", done, 1);
    check("dz_lo", lo, 32'hFFFF_FFFF);
    check("dz_hi", hi, 32'd5);

    // MTHI/MTLO, then cancelled DIV
    issue(OP_MTHI, 32'h11, 32'd0);
    check("mthi_hi", hi, 32'h11);
    check("mthi_no_done", done, 0);
    check("mthi_ready", req_ready, 1);
    issue(OP_MTLO, 32'h22, 32'd0);
    check("mtlo_lo", lo, 32'h22);
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (10) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_c11_ready", req_ready, 1);
    check("cancel_c11_done", done, 0);
    seen_done = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done !== 1'b0) seen_done++;
    end
    check("cancel_no_done", seen_done, 0);
    check("cancel_hi", hi, 32'h11);
    check("cancel_lo", lo, 32'h22);

    // Request presented together with cancel is not accepted
    req_valid = 1'b1;
    cancel    = 1'b1;
    op        = OP_MTHI;
    a         = 32'h99;
    tick();
    req_valid = 1'b0;
    cancel    = 1'b0;
    check("cancel_blocks_accept", hi, 32'h11);

    // Undefined op is consumed without effect
    issue(3'd7, 32'hAB, 32'hCD);
    check("undef_ready", req_ready, 1);
    check("undef_done", done, 0);
    check("undef_hi", hi, 32'h11);
    check("undef_lo", lo, 32'h22);

    // Asynchronous reset in the middle of a MULT
    issue(OP_MULT, 32'd3, 32'd4);
    tick();
    #2;
    resetn = 1'b0;
    #1;
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_busy", busy, 0);
    tick();
    tick();
    resetn = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done !== 1'b0) seen_done++;
    end
    check("arst_no_done", seen_done, 0);
    check("arst_lo_after", lo, 0);

    // Back-to-back: DIVU 9/3 then MTLO 7 with req_valid held high
    req_valid = 1'b1;
    op        = OP_DIVU;
    a         = 32'd9;
    b         = 32'd3;
    tick();
    op = OP_MTLO;
    a  = 32'd7;
    b  = 32'd0;
    repeat (32) tick();
    check("b2b_c32_ready", req_ready, 0);
    check("b2b_c32_lo", lo, 0);
    tick();
    check("b2b_c33_done", done, 1);
    check("b2b_c33_ready", req_ready, 1);
    check("b2b_quot", lo, 32'd3);
    check("b2b_rem", hi, 32'd0);
    tick();
    req_valid = 1'b0;
    check("b2b_mtlo_lo", lo, 32'd7);
    check("b2b_mtlo_hi", hi, 32'd0);
    check("b2b_mtlo_done", done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
